// File: rtl/fp_pkg.sv
// Shared types and constants for the FP multiplier back end.
// Holds the encoder FSM states and the IEEE single-precision field constants.
package fp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      NORM,
      ROUND,
      PACK,
      DONE
   } state_t;

   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX = 255;
   localparam int MANT_IN_W = 48;
   localparam int FRAC_W = 23;
   localparam logic [7:0] FLOAT_INF_EXP = 8'hFF;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalized 24-bit significand.
// The hidden bit is always set, so a carry-out happens only when kept is all ones.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [FRAC_W:0]   kept,
   input  logic              guard,
   input  logic              sticky,
   output logic [FRAC_W-1:0] frac,
   output logic              carry
);

   logic inc;

   assign inc = guard & (sticky | kept[0]);
   assign frac = kept[FRAC_W-1:0] + FRAC_W'(inc);
   assign carry = inc & (&kept);

endmodule

// File: rtl/fp_enco.sv
// Float encoder: normalizes a 48-bit significand product one bit per cycle,
// rounds to nearest-even and packs an IEEE-754 single-precision word.
module fp_enco #(
   parameter int MANT_IN_W = 48,
   parameter int EXP_IN_W  = 10,
   parameter int EXP_W     = 8,
   parameter int FRAC_W    = 23
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                signo,
   input  logic [EXP_IN_W-1:0] exponente,
   input  logic [MANT_IN_W-1:0] mantissa,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         float_num,
   output logic                overflow,
   output logic                underflow
);

   import fp_pkg::state_t;
   import fp_pkg::IDLE;
   import fp_pkg::NORM;
   import fp_pkg::ROUND;
   import fp_pkg::PACK;
   import fp_pkg::DONE;
   import fp_pkg::EXP_MAX;
   import fp_pkg::FLOAT_INF_EXP;

   // One extra exponent bit so the +/-1 adjustments never wrap.
   localparam int EW = EXP_IN_W + 1;
   localparam int G  = MANT_IN_W - 2 - (FRAC_W + 1);
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_ZERO = '0;
   localparam logic signed [EW-1:0] E_MAX  = EW'(EXP_MAX);

   state_t                 state;
   logic                   sgn_q;
   logic signed [EW-1:0]   exp_q;
   logic [MANT_IN_W-1:0]   man_q;
   logic                   sticky_q;
   logic                   zero_q;
   logic [FRAC_W-1:0]      frac_q;

   logic [FRAC_W:0]        kept;
   logic                   guard;
   logic                   sticky;
   logic [FRAC_W-1:0]      rnd_frac;
   logic                   rnd_carry;

   assign in_ready = (state == IDLE);

   assign kept   = man_q[MANT_IN_W-2 -: FRAC_W+1];
   assign guard  = man_q[G];
   assign sticky = (|man_q[G-1:0]) | sticky_q;

   fp_round_rne u_round (
      .kept   (kept),
      .guard  (guard),
      .sticky (sticky),
      .frac   (rnd_frac),
      .carry  (rnd_carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sgn_q     <= 1'b0;
         exp_q     <= '0;
         man_q     <= '0;
         sticky_q  <= 1'b0;
         zero_q    <= 1'b0;
         frac_q    <= '0;
         out_valid <= 1'b0;
         float_num <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sgn_q    <= signo;
                  exp_q    <= {exponente[EXP_IN_W-1], exponente};
                  man_q    <= mantissa;
                  sticky_q <= 1'b0;
                  zero_q   <= 1'b0;
                  state    <= NORM;
               end
            end
            NORM: begin
               if (man_q == '0) begin
                  zero_q <= 1'b1;
                  state  <= PACK;
               end else if (man_q[MANT_IN_W-1]) begin
                  man_q    <= man_q >> 1;
                  sticky_q <= sticky_q | man_q[0];
                  exp_q    <= exp_q + E_ONE;
                  state    <= ROUND;
               end else if (man_q[MANT_IN_W-2]) begin
                  state <= ROUND;
               end else begin
                  man_q <= man_q << 1;
                  exp_q <= exp_q - E_ONE;
                  if (exp_q <= E_ONE) state <= PACK;
               end
            end
            ROUND: begin
               frac_q <= rnd_frac;
               if (rnd_carry) exp_q <= exp_q + E_ONE;
               state <= PACK;
            end
            PACK: begin
               overflow  <= 1'b0;
               underflow <= 1'b0;
               state     <= DONE;
               if (zero_q) begin
                  float_num <= {sgn_q, {(EXP_W+FRAC_W){1'b0}}};
               end else if (exp_q >= E_MAX) begin
                  float_num <= {sgn_q, FLOAT_INF_EXP, {FRAC_W{1'b0}}};
                  overflow  <= 1'b1;
               end else if (exp_q <= E_ZERO) begin
                  float_num <= {sgn_q, {(EXP_W+FRAC_W){1'b0}}};
                  underflow <= 1'b1;
               end else begin
                  float_num <= {sgn_q, exp_q[EXP_W-1:0], frac_q};
               end
            end
            DONE: begin
               // Result word settles one edge before it is advertised.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_enco.sv
// Directed-vector bench for fp_enco.
// Expected words are hand-computed IEEE single-precision encodings.
module tb_fp_enco;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        signo = 1'b0;
   logic [9:0]  exponente = '0;
   logic [47:0] mantissa = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] float_num;
   logic        overflow;
   logic        underflow;

   int n_vec = 0;
   int n_bad = 0;

   fp_enco dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .signo     (signo),
      .exponente (exponente),
      .mantissa  (mantissa),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .float_num (float_num),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic run_op(input string tag, input logic s,
                         input logic [9:0] e, input logic [47:0] m,
                         input logic [31:0] want, input logic ov,
                         input logic uf, input int lat, input int hold);
      int cyc;
      bit seen;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      signo = s;
      exponente = e;
      mantissa = m;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 0;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         check({tag, "_busy"}, 32'(in_ready), 32'd0);
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      check({tag, "_lat"}, 32'(cyc), 32'(lat));
      check({tag, "_word"}, float_num, want);
      check({tag, "_ov"}, 32'(overflow), 32'(ov));
      check({tag, "_uf"}, 32'(underflow), 32'(uf));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_w"}, float_num, want);
         check({tag, "_hold_r"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_word", float_num, 32'h0);
      check("rst_ov", 32'(overflow), 32'd0);
      check("rst_uf", 32'(underflow), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("three", 1'b0, 10'd128, 48'h600000000000,
             32'h40400000, 1'b0, 1'b0, 4, 0);
      run_op("rshift", 1'b0, 10'd127, 48'h900000000000,
             32'h40100000, 1'b0, 1'b0, 4, 0);
      run_op("carry", 1'b0, 10'd127, 48'h7FFFFFC00000,
             32'h40000000, 1'b0, 1'b0, 4, 0);
      run_op("tie", 1'b0, 10'd127, 48'h400000400000,
             32'h3F800000, 1'b0, 1'b0, 4, 0);
      run_op("lshift", 1'b0, 10'd127, 48'h100000000000,
             32'h3E800000, 1'b0, 1'b0, 6, 0);
      run_op("ovf", 1'b1, 10'd300, 48'h400000000000,
             32'hFF800000, 1'b1, 1'b0, 4, 0);
      run_op("udf", 1'b0, 10'h3FB, 48'h400000000000,
             32'h00000000, 1'b0, 1'b1, 4, 0);
      run_op("zero", 1'b1, 10'd127, 48'h0,
             32'h80000000, 1'b0, 1'b0, 3, 5);

      // Long normalization, interrupted by reset
      signo = 1'b0;
      exponente = 10'd127;
      mantissa = 48'h000000000001;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("mid_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_word", float_num, 32'h0);
      check("mid_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("after", 1'b0, 10'd128, 48'h600000000000,
             32'h40400000, 1'b0, 1'b0, 4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
